dmem_bytelane_ctrl: RTL and testbench
=====================================

DMEM_BYTELANE_CTRL -- requirements
Module: dmem_bytelane_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16384, meaning number of 32-bit words (4 byte lanes each).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill memory after reset when 1.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_i, input, 1 bit: access request.
REQ-007 SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port unsigned_i, input, 1 bit: 1 = zero-extend sub-word loads.
REQ-010 SHALL have port addr_i, input, ADDR_W bits: byte address.
REQ-011 SHALL have port wdata_i, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port ready_o, output, 1 bit: request accepted when req_i && ready_o.
REQ-013 SHALL have port rvalid_o, output, 1 bit: one-cycle pulse marking load response.
REQ-014 SHALL have port rdata_o, output, 32 bits: extended load data.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle pulse marking a faulted access.
REQ-016 SHALL have port busy_o, output, 1 bit: clear sequence in progress.

Function
REQ-017 SHALL implement FSM states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-018 In CLEAR, SHALL write 0 to word index 0..DEPTH_WORDS-1, one word per cycle, all lanes, then enter READY on the cycle after index DEPTH_WORDS-1 is written.
REQ-019 ready_o SHALL be 1 only in READY; busy_o SHALL be 1 only in CLEAR; requests in CLEAR SHALL be ignored, with no response.
REQ-020 Word index SHALL be addr_i[ADDR_W-1:2]; lane offset SHALL be addr_i[1:0].
REQ-021 Fault SHALL be: size_i=11; half with addr_i[0]=1; word with addr_i[1:0]!=00; word index >= DEPTH_WORDS.
REQ-022 Accepted non-faulting store SHALL write at that edge only the lanes selected: byte -> lane addr[1:0] gets wdata_i[7:0]; half -> lanes addr[1]*2 and +1 get wdata_i[15:0]; word -> all lanes.
REQ-023 Accepted store SHALL not assert rvalid_o; unselected lanes SHALL be unchanged.
REQ-024 Accepted load SHALL assert rvalid_o exactly one cycle later, with rdata_o valid in that cycle (1-cycle latency).
REQ-025 Load data SHALL be the selected byte/half shifted to bit 0, sign-extended from bit 7/15 unless unsigned_i=1, which zero-extends; word loads are unextended.
REQ-026 Faulting access SHALL not modify memory; err_o SHALL pulse one cycle after acceptance; a faulting load SHALL also pulse rvalid_o with rdata_o=0.
REQ-027 rdata_o SHALL hold its last value until the next load response.
REQ-028 Back-to-back accesses SHALL be accepted every cycle in READY; a load accepted the cycle after a store to the same word SHALL return post-store data.

Reset
REQ-029 On rst_i=1 at a clock edge: rvalid_o=0, err_o=0, rdata_o=0, FSM per REQ-017, clear index=0; reset during CLEAR SHALL restart the clear from index 0.
REQ-030 Reset SHALL not alter memory contents except through the subsequent clear sequence.

Verification
REQ-031 Reset, DEPTH_WORDS=16, CLEAR_ON_RESET=1 -> busy_o=1, ready_o=0 for 16 cycles, then ready_o=1; load word addr 0x3C -> rdata_o=0x00000000.
REQ-032 Store word 0x80FF7F01 to 0x10, then load byte 0x11 signed -> 0x0000007F; load byte 0x13 signed -> 0xFFFFFF80; load half 0x12 unsigned -> 0x000080FF.
REQ-033 Store byte 0xAA to 0x12 over 0x11223344 at word 0x10 -> load word 0x10 returns 0x11AA3344.
REQ-034 Load half at 0x01, store word at 0x02, size_i=11, word index 16 (DEPTH_WORDS=16) -> err_o pulse each; loads give rvalid_o=1, rdata_o=0; memory unchanged.
REQ-035 Store 0xDEADBEEF to 0x20 at cycle N, load 0x20 at N+1 -> rvalid_o at N+2 with 0xDEADBEEF; rst_i at clear index 7 -> busy_o stays high a further 16 cycles.

Source files
------------

// File: rtl/dmem_bytelane_ctrl.sv
// Byte-lane data memory with sub-word loads/stores, alignment faults
// and a power-on zero-fill sequence.
module dmem_bytelane_ctrl #(
    parameter int DEPTH_WORDS    = 16384,
    parameter int ADDR_W         = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH_WORDS);
    localparam logic [IDX_W:0] LAST_L  = (IDX_W+1)'(DEPTH_WORDS - 1);
    localparam logic [IDX_W:0] ONE_L   = (IDX_W+1)'(1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t         state_q, state_d;
    logic [IDX_W:0] clr_idx_q, clr_idx_d;
    logic           rvalid_q, rvalid_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       off;
    logic             fault;
    logic             accept;
    logic             wr_en;
    logic [3:0]       be;
    logic [31:0]      wlane;
    logic [31:0]      rd_word;
    logic [31:0]      sh;
    logic [31:0]      ext;

    assign word_idx = addr_i[ADDR_W-1:2];
    assign off      = addr_i[1:0];
    assign accept   = req_i && (state_q == READY);
    assign wr_en    = accept && we_i && !fault;

    // Store data is replicated across lanes so the byte enables alone pick placement
    always_comb begin
        fault = 1'b0;
        be    = 4'b0000;
        wlane = wdata_i;
        case (size_i)
            2'b00: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                fault = off[0];
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                fault = (off != 2'b00);
                be    = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
        if ({1'b0, word_idx} >= DEPTH_L)
            fault = 1'b1;
    end

    always_comb begin
        rd_word = fault ? 32'h0 : mem[word_idx];
        sh      = rd_word >> {off, 3'b000};
        case (size_i)
            2'b00:   ext = unsigned_i ? {24'h0, sh[7:0]}
                                      : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ext = unsigned_i ? {16'h0, sh[15:0]}
                                      : {{16{sh[15]}}, sh[15:0]};
            default: ext = rd_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + ONE_L;
                if (clr_idx_q == LAST_L)
                    state_d = READY;
            end
            READY: begin
                if (accept) begin
                    err_d = fault;
                    if (!we_i) begin
                        rvalid_d = 1'b1;
                        rdata_d  = fault ? 32'h0 : ext;
                    end
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_idx_q <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory has no reset; contents change only via the clear walk or stores
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem[clr_idx_q[IDX_W-1:0]] <= 32'h0;
            end else if (wr_en) begin
                for (int i = 0; i < 4; i++)
                    if (be[i])
                        mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign ready_o  = (state_q == READY);
    assign busy_o   = (state_q == CLEAR);
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Directed bench for dmem_bytelane_ctrl with a 16-word memory.
module tb_dmem_bytelane_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [15:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    dmem_bytelane_ctrl #(
        .DEPTH_WORDS(16),
        .ADDR_W(16),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .we_i(we_i),
        .size_i(size_i),
        .unsigned_i(unsigned_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .ready_o(ready_o),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .err_o(err_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [15:0] a, input logic [31:0] wd);
        req_i      = 1'b1;
        we_i       = we;
        size_i     = sz;
        unsigned_i = uns;
        addr_i     = a;
        wdata_i    = wd;
    endtask

    task automatic idle();
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic store(input string tag, input logic [1:0] sz,
                         input logic [15:0] a, input logic [31:0] wd,
                         input logic exp_err);
        put(1'b1, sz, 1'b0, a, wd);
        cyc();
        idle();
        chk({tag, "_rvalid"}, {31'h0, rvalid_o}, 32'h0);
        chk({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [31:0] exp,
                        input logic exp_err);
        put(1'b0, sz, uns, a, 32'h0);
        cyc();
        idle();
        chk({tag, "_rvalid"}, {31'h0, rvalid_o}, 32'h1);
        chk({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
        chk({tag, "_rdata"}, rdata_o, exp);
    endtask

    task automatic clear_walk(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
            chk({tag, "_ready"}, {31'h0, ready_o}, 32'h0);
            cyc();
        end
        chk({tag, "_done_ready"}, {31'h0, ready_o}, 32'h1);
        chk({tag, "_done_busy"}, {31'h0, busy_o}, 32'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        size_i = 2'b10;
        unsigned_i = 1'b0;
        addr_i = 16'h0;
        wdata_i = 32'h0;
        cyc();
        rst_i = 1'b0;
        chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);

        // first three clear cycles carry a load that must be ignored
        for (int i = 0; i < 3; i++) begin
            chk("clr_busy", {31'h0, busy_o}, 32'h1);
            put(1'b0, 2'b10, 1'b0, 16'h0000, 32'h0);
            cyc();
            idle();
            chk("clr_ignored", {31'h0, rvalid_o}, 32'h0);
            chk("clr_noerr", {31'h0, err_o}, 32'h0);
        end
        for (int i = 3; i < 16; i++) begin
            chk("clr_busy", {31'h0, busy_o}, 32'h1);
            chk("clr_ready", {31'h0, ready_o}, 32'h0);
            cyc();
        end
        chk("post_clr_ready", {31'h0, ready_o}, 32'h1);
        chk("post_clr_busy", {31'h0, busy_o}, 32'h0);

        load("ld_3c", 2'b10, 1'b0, 16'h003C, 32'h0000_0000, 1'b0);
        cyc();
        chk("rvalid_pulse", {31'h0, rvalid_o}, 32'h0);

        store("st_w10", 2'b10, 16'h0010, 32'h80FF_7F01, 1'b0);
        load("lb_11s", 2'b00, 1'b0, 16'h0011, 32'h0000_007F, 1'b0);
        load("lb_13s", 2'b00, 1'b0, 16'h0013, 32'hFFFF_FF80, 1'b0);
        load("lh_12u", 2'b01, 1'b1, 16'h0012, 32'h0000_80FF, 1'b0);
        load("lh_12s", 2'b01, 1'b0, 16'h0012, 32'hFFFF_80FF, 1'b0);
        load("lb_12u", 2'b00, 1'b1, 16'h0012, 32'h0000_00FF, 1'b0);
        load("lb_10s", 2'b00, 1'b0, 16'h0010, 32'h0000_0001, 1'b0);

        store("st_w10b", 2'b10, 16'h0010, 32'h1122_3344, 1'b0);
        store("sb_12", 2'b00, 16'h0012, 32'h1234_56AA, 1'b0);
        load("lw_10a", 2'b10, 1'b0, 16'h0010, 32'h11AA_3344, 1'b0);
        store("sh_10", 2'b01, 16'h0010, 32'h5555_BEEF, 1'b0);
        cyc();
        chk("rdata_hold", rdata_o, 32'h11AA_3344);
        load("lw_10b", 2'b10, 1'b0, 16'h0010, 32'h11AA_BEEF, 1'b0);

        load("flt_lh01", 2'b01, 1'b0, 16'h0001, 32'h0, 1'b1);
        cyc();
        chk("err_pulse", {31'h0, err_o}, 32'h0);
        store("flt_sw02", 2'b10, 16'h0002, 32'hFFFF_FFFF, 1'b1);
        load("flt_ld11", 2'b11, 1'b0, 16'h0010, 32'h0, 1'b1);
        store("flt_st11", 2'b11, 16'h0010, 32'hFFFF_FFFF, 1'b1);
        load("flt_oob", 2'b10, 1'b0, 16'h0040, 32'h0, 1'b1);
        store("flt_soob", 2'b10, 16'h0040, 32'hFFFF_FFFF, 1'b1);
        load("unch_w0", 2'b10, 1'b0, 16'h0000, 32'h0000_0000, 1'b0);
        load("unch_w10", 2'b10, 1'b0, 16'h0010, 32'h11AA_BEEF, 1'b0);

        put(1'b1, 2'b10, 1'b0, 16'h0020, 32'hDEAD_BEEF);
        cyc();
        put(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0);
        chk("b2b_st_rvalid", {31'h0, rvalid_o}, 32'h0);
        cyc();
        idle();
        chk("b2b_rvalid", {31'h0, rvalid_o}, 32'h1);
        chk("b2b_rdata", rdata_o, 32'hDEAD_BEEF);

        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("rst2_rdata", rdata_o, 32'h0);
        for (int i = 0; i < 7; i++)
            cyc();
        chk("pre_rst3_busy", {31'h0, busy_o}, 32'h1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        clear_walk("rst_mid");
        load("cleared_20", 2'b10, 1'b0, 16'h0020, 32'h0000_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
